// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage with a request/acknowledge data-memory bus.
//
// Non-memory ops pass straight through to MEM/WB in one cycle. An aligned load/store
// stalls upstream, issues one registered bus request and waits for dmem_ack. The wait
// is bounded by TIMEOUT; a timeout writes back a bus_err slot. A misaligned access never
// reaches the bus and writes back a misalign_err slot.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   valid_m .. funct3_m           EX/MEM slot (held by the pipeline while mem_stall=1)
//   dmem_req/we/addr/wdata/wstrb  registered bus request, stable until acknowledged
//   dmem_ack, dmem_rdata          bus response
//   mem_stall                     combinational hold for EX/MEM and upstream stages
//   wb_* / mem_wb_data            registered MEM/WB slot (also the EX forwarding source)
//   misalign_err, bus_err         single-cycle error flags, valid only with wb_valid
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] read_data2_m,
    input  logic [4:0]  rd_m,
    input  logic        reg_write_m,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic        mem_to_reg_m,
    input  logic [2:0]  funct3_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] mem_wb_data,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        mis_q, mis_d, berr_q, berr_d;

    logic        memop, aligned, timeout_hit;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val, st_data;
    logic [3:0]  st_strb;

    assign off         = alu_result_m[1:0];
    assign memop       = valid_m & (mem_read_m | mem_write_m);
    assign timeout_hit = (state_q == StAccess) && !dmem_ack && (cnt_q == 8'(TIMEOUT - 1));

    // Access size comes from funct3[1:0]; sizes 10/11 are treated as a word.
    always_comb begin
        case (funct3_m[1:0])
            2'b00: begin
                aligned = 1'b1;
                st_data = {4{read_data2_m[7:0]}};
                st_strb = 4'b0001 << off;
            end
            2'b01: begin
                aligned = ~off[0];
                st_data = {2{read_data2_m[15:0]}};
                st_strb = 4'b0011 << off;
            end
            default: begin
                aligned = (off == 2'b00);
                st_data = read_data2_m;
                st_strb = 4'b1111;
            end
        endcase
    end

    // Load lane selection and extension.
    always_comb begin
        case (off)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_m)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_val = {24'b0, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_val = {16'b0, ld_half};
            default: load_val = dmem_rdata;
        endcase
    end

    // Stall is released in the timeout cycle so the error slot can retire.
    always_comb begin
        mem_stall = 1'b0;
        if (!rst) begin
            case (state_q)
                StIdle:   mem_stall = memop & aligned;
                default:  mem_stall = !dmem_ack && !timeout_hit;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        // MEM/WB defaults to a bubble; payload fields hold.
        wb_valid_d = 1'b0;
        wb_rw_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        mis_d      = 1'b0;
        berr_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (memop && aligned) begin
                    state_d = StAccess;
                    cnt_d   = 8'd0;
                    req_d   = 1'b1;
                    we_d    = mem_write_m;
                    addr_d  = {alu_result_m[31:2], 2'b00};
                    wdata_d = st_data;
                    wstrb_d = mem_write_m ? st_strb : 4'b0000;
                end else if (memop) begin
                    wb_valid_d = 1'b1;
                    mis_d      = 1'b1;
                    wb_rd_d    = rd_m;
                    wb_data_d  = alu_result_m;
                end else begin
                    wb_valid_d = valid_m;
                    wb_rw_d    = reg_write_m & valid_m;
                    wb_rd_d    = rd_m;
                    wb_data_d  = alu_result_m;
                end
            end
            default: begin
                if (dmem_ack) begin
                    state_d    = StIdle;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rw_d    = reg_write_m;
                    wb_rd_d    = rd_m;
                    wb_data_d  = mem_to_reg_m ? load_val : alu_result_m;
                end else if (timeout_hit) begin
                    state_d    = StIdle;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    berr_d     = 1'b1;
                    wb_rd_d    = rd_m;
                    wb_data_d  = alu_result_m;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            mis_q      <= mis_d;
            berr_q     <= berr_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_wstrb   = wstrb_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_rw_q;
    assign mem_wb_data  = wb_data_q;
    assign misalign_err = mis_q;
    assign bus_err      = berr_q;

endmodule
